// File: rtl/riscv_pkg.sv
// Shared types and constants for the writeback stage: result-select encoding
// and load funct3 codes.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Combinational load alignment and sign/zero extension of a 32-bit memory word.
// Misaligned halfword offsets fall back to the half selected by offset[1].
module load_extend
  import riscv_pkg::*;
#(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter bit LOAD_EXT = 1'b1
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    ext      = word;
    if (LOAD_EXT) begin
      case (funct3)
        F3_LB:   ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
        F3_LBU:  ext = {{(XLEN-8){1'b0}}, byte_sel};
        F3_LH:   ext = {{(XLEN-16){half_sel[15]}}, half_sel};
        F3_LHU:  ext = {{(XLEN-16){1'b0}}, half_sel};
        default: ext = word;
      endcase
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with result select, load extension, x0 write
// suppression and a retired-instruction counter.
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int REG_ADDR_W = 5,
  parameter bit LOAD_EXT   = 1'b1,
  parameter int CNT_W      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallW,
  input  logic                  FlushW,
  input  logic                  ValidM,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [2:0]            Funct3M,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [XLEN-1:0]       ALUResultM,
  input  logic [XLEN-1:0]       ReadDataM,
  input  logic [XLEN-1:0]       PCPlus4M,
  input  logic [XLEN-1:0]       ImmExtM,
  output logic [XLEN-1:0]       ResultW,
  output logic                  RegWriteW,
  output logic [REG_ADDR_W-1:0] RdW,
  output logic                  ValidW,
  output logic [CNT_W-1:0]      InstRetW
);

  logic                  valid_q,    valid_d;
  logic                  regwrite_q, regwrite_d;
  result_src_e           src_q,      src_d;
  logic [2:0]            funct3_q,   funct3_d;
  logic [REG_ADDR_W-1:0] rd_q,       rd_d;
  logic [XLEN-1:0]       alu_q,      alu_d;
  logic [XLEN-1:0]       rdata_q,    rdata_d;
  logic [XLEN-1:0]       pc4_q,      pc4_d;
  logic [XLEN-1:0]       imm_q,      imm_d;
  logic [CNT_W-1:0]      instret_q,  instret_d;
  logic                  advance;
  logic [XLEN-1:0]       load_ext;

  // A flush overrides a stall, so the W slot is vacated on either.
  always_comb begin
    advance    = FlushW | ~StallW;
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    src_d      = src_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    alu_d      = alu_q;
    rdata_d    = rdata_q;
    pc4_d      = pc4_q;
    imm_d      = imm_q;
    instret_d  = instret_q;

    if (advance && valid_q) begin
      instret_d = instret_q + CNT_W'(1);
    end

    if (FlushW) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      src_d      = RES_ALU;
      funct3_d   = '0;
      rd_d       = '0;
      alu_d      = '0;
      rdata_d    = '0;
      pc4_d      = '0;
      imm_d      = '0;
    end else if (!StallW) begin
      valid_d    = ValidM;
      regwrite_d = RegWriteM;
      src_d      = result_src_e'(ResultSrcM);
      funct3_d   = Funct3M;
      rd_d       = RdM;
      alu_d      = ALUResultM;
      rdata_d    = ReadDataM;
      pc4_d      = PCPlus4M;
      imm_d      = ImmExtM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      src_q      <= RES_ALU;
      funct3_q   <= '0;
      rd_q       <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      imm_q      <= '0;
      instret_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      src_q      <= src_d;
      funct3_q   <= funct3_d;
      rd_q       <= rd_d;
      alu_q      <= alu_d;
      rdata_q    <= rdata_d;
      pc4_q      <= pc4_d;
      imm_q      <= imm_d;
      instret_q  <= instret_d;
    end
  end

  load_extend #(
    .XLEN     (XLEN),
    .LOAD_EXT (LOAD_EXT)
  ) u_load_extend (
    .funct3 (funct3_q),
    .offset (alu_q[1:0]),
    .word   (rdata_q),
    .ext    (load_ext)
  );

  // Result select and write enable are decoded after the register.
  always_comb begin
    case (src_q)
      RES_ALU:  ResultW = alu_q;
      RES_LOAD: ResultW = load_ext;
      RES_PC4:  ResultW = pc4_q;
      RES_IMM:  ResultW = imm_q;
      default:  ResultW = alu_q;
    endcase
    RegWriteW = regwrite_q & valid_q & (rd_q != '0);
    RdW       = rd_q;
    ValidW    = valid_q;
    InstRetW  = instret_q;
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Randomised and directed bench for writeback_stage with a behavioural
// reference model of the W slot and the retire counter.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst, StallW, FlushW, ValidM, RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, ReadDataM, PCPlus4M, ImmExtM;

  logic [31:0] ResultW;
  logic        RegWriteW, ValidW;
  logic [4:0]  RdW;
  logic [63:0] InstRetW;

  logic [31:0] res4;
  logic        we4, v4;
  logic [4:0]  rd4;
  logic [3:0]  inst4;

  int checks = 0;
  int failures = 0;

  // reference model of the instruction held in W
  logic        mv, mrw;
  logic [1:0]  msrc;
  logic [2:0]  mf3;
  logic [4:0]  mrd;
  logic [31:0] malu, mrdat, mpc4, mimm;
  logic [63:0] mcnt;

  always #5 clk = ~clk;

  writeback_stage u_dut (
    .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RdM(RdM),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
    .ResultW(ResultW), .RegWriteW(RegWriteW), .RdW(RdW), .ValidW(ValidW), .InstRetW(InstRetW)
  );

  writeback_stage #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RdM(RdM),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
    .ResultW(res4), .RegWriteW(we4), .RdW(rd4), .ValidW(v4), .InstRetW(inst4)
  );

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [1:0] off, logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'h0000_00FF;
    h = (w >> (16 * (off / 2))) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_result();
    case (msrc)
      2'd0:    return malu;
      2'd1:    return model_load(mf3, malu[1:0], mrdat);
      2'd2:    return mpc4;
      default: return mimm;
    endcase
  endfunction

  function automatic logic exp_we();
    return mrw && mv && (mrd != 5'd0);
  endfunction

  task automatic model_clear();
    mv = 0; mrw = 0; msrc = 0; mf3 = 0; mrd = 0;
    malu = 0; mrdat = 0; mpc4 = 0; mimm = 0;
  endtask

  // Advance model from the current (pre-edge) inputs, then clock the DUT.
  task automatic tick();
    if (rst) begin
      model_clear();
      mcnt = 0;
    end else begin
      if ((FlushW || !StallW) && mv) mcnt = mcnt + 1;
      if (FlushW) model_clear();
      else if (!StallW) begin
        mv = ValidM; mrw = RegWriteM; msrc = ResultSrcM; mf3 = Funct3M; mrd = RdM;
        malu = ALUResultM; mrdat = ReadDataM; mpc4 = PCPlus4M; mimm = ImmExtM;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_m();
    ValidM = 1'($urandom); RegWriteM = 1'($urandom); ResultSrcM = 2'($urandom);
    Funct3M = 3'($urandom); RdM = 5'($urandom);
    ALUResultM = $urandom; ReadDataM = $urandom; PCPlus4M = $urandom; ImmExtM = $urandom;
  endtask

  task automatic set_m(logic v, logic rw, logic [1:0] src, logic [2:0] f3, logic [4:0] rd,
                       logic [31:0] alu, logic [31:0] rdat, logic [31:0] pc4, logic [31:0] imm);
    ValidM = v; RegWriteM = rw; ResultSrcM = src; Funct3M = f3; RdM = rd;
    ALUResultM = alu; ReadDataM = rdat; PCPlus4M = pc4; ImmExtM = imm;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; StallW = 0; FlushW = 0;
    randomize_m(); ValidM = 1; RegWriteM = 1; RdM = 5'd9;
    tick(); tick();
    checks++;
    if (ResultW !== 32'd0 || RegWriteW !== 1'b0 || RdW !== 5'd0 || ValidW !== 1'b0 ||
        InstRetW !== 64'd0 || inst4 !== 4'd0) begin
      failures++;
      $display("FAIL reset_state: got res=%h we=%b rd=%0d v=%b ir=%0d ir4=%0d, want all 0",
               ResultW, RegWriteW, RdW, ValidW, InstRetW, inst4);
    end
    rst = 0; ValidM = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (InstRetW !== 64'd0 || ValidW !== 1'b0) begin
        failures++;
        $display("FAIL idle_no_retire: got ir=%0d v=%b, want 0 0", InstRetW, ValidW);
      end
    end
  endtask

  task automatic test_result_mux();
    logic [31:0] want [4];
    want[0] = 32'd5; want[1] = 32'd10; want[2] = 32'd15; want[3] = 32'd20;
    for (int s = 0; s < 4; s++) begin
      set_m(1, 1, 2'(s), 3'b010, 5'd3, 32'd5, 32'd10, 32'd15, 32'd20);
      tick();
      checks++;
      if (ResultW !== want[s] || ResultW !== exp_result() || RegWriteW !== 1'b1 || RdW !== 5'd3) begin
        failures++;
        $display("FAIL result_mux src=%0d: got res=%0d we=%b rd=%0d, want res=%0d we=1 rd=3",
                 s, ResultW, RegWriteW, RdW, want[s]);
      end
    end
  endtask

  task automatic test_load_extend();
    logic [1:0]  offs [11];
    logic [2:0]  f3s  [11];
    logic [31:0] want [11];
    offs[0]=1; f3s[0]=3'd0; want[0]=32'hFFFF_FFAA;
    offs[1]=1; f3s[1]=3'd4; want[1]=32'h0000_00AA;
    offs[2]=2; f3s[2]=3'd1; want[2]=32'hFFFF_8899;
    offs[3]=2; f3s[3]=3'd5; want[3]=32'h0000_8899;
    offs[4]=0; f3s[4]=3'd0; want[4]=32'hFFFF_FFBB;
    offs[5]=3; f3s[5]=3'd4; want[5]=32'h0000_0088;
    offs[6]=0; f3s[6]=3'd5; want[6]=32'h0000_AABB;
    offs[7]=1; f3s[7]=3'd1; want[7]=32'hFFFF_AABB;
    offs[8]=3; f3s[8]=3'd1; want[8]=32'hFFFF_8899;
    offs[9]=2; f3s[9]=3'd2; want[9]=32'h8899_AABB;
    offs[10]=1; f3s[10]=3'd3; want[10]=32'h8899_AABB;
    for (int i = 0; i < 11; i++) begin
      set_m(1, 1, 2'd1, f3s[i], 5'd4, {30'h1000, offs[i]}, 32'h8899_AABB, 32'd0, 32'd0);
      tick();
      checks++;
      if (ResultW !== want[i] || ResultW !== exp_result()) begin
        failures++;
        $display("FAIL load_ext f3=%0d off=%0d: got %h, want %h", f3s[i], offs[i], ResultW, want[i]);
      end
    end
  endtask

  task automatic test_x0();
    set_m(1, 1, 2'd0, 3'd2, 5'd0, 32'h1, 32'h0, 32'h0, 32'h0);
    tick();
    checks++;
    if (RegWriteW !== 1'b0) begin
      failures++;
      $display("FAIL x0_suppress: got we=%b, want 0", RegWriteW);
    end
    RdM = 5'd7;
    tick();
    checks++;
    if (RegWriteW !== 1'b1 || RdW !== 5'd7) begin
      failures++;
      $display("FAIL rd7_write: got we=%b rd=%0d, want we=1 rd=7", RegWriteW, RdW);
    end
    ValidM = 0;
    tick();
    checks++;
    if (RegWriteW !== 1'b0 || ValidW !== 1'b0) begin
      failures++;
      $display("FAIL invalid_no_write: got we=%b v=%b, want 0 0", RegWriteW, ValidW);
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] held_res;
    logic [63:0] held_cnt;
    do_reset();
    set_m(1, 1, 2'd3, 3'd2, 5'd12, 32'h11, 32'h22, 32'h33, 32'hCAFE_0001);
    tick();
    held_res = 32'hCAFE_0001;
    held_cnt = mcnt;
    StallW = 1;
    for (int i = 0; i < 3; i++) begin
      randomize_m();
      tick();
      checks++;
      if (ResultW !== held_res || RdW !== 5'd12 || ValidW !== 1'b1 || RegWriteW !== 1'b1 ||
          InstRetW !== held_cnt || InstRetW !== mcnt) begin
        failures++;
        $display("FAIL stall_hold cyc%0d: got res=%h rd=%0d v=%b we=%b ir=%0d, want res=%h rd=12 v=1 we=1 ir=%0d",
                 i, ResultW, RdW, ValidW, RegWriteW, InstRetW, held_res, held_cnt);
      end
    end
    StallW = 0; FlushW = 1; ValidM = 1; RegWriteM = 1; RdM = 5'd5;
    tick();
    checks++;
    if (ValidW !== 1'b0 || RegWriteW !== 1'b0 || InstRetW !== mcnt || mcnt !== held_cnt + 1) begin
      failures++;
      $display("FAIL flush: got v=%b we=%b ir=%0d, want v=0 we=0 ir=%0d", ValidW, RegWriteW, InstRetW, held_cnt + 1);
    end
    FlushW = 0;
    set_m(1, 1, 2'd0, 3'd2, 5'd9, 32'h77, 32'h0, 32'h0, 32'h0);
    tick();
    StallW = 1; FlushW = 1;
    tick();
    checks++;
    if (ValidW !== 1'b0 || RegWriteW !== 1'b0) begin
      failures++;
      $display("FAIL flush_over_stall: got v=%b we=%b, want v=0 we=0", ValidW, RegWriteW);
    end
    StallW = 0; FlushW = 0;
    do_reset();
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      randomize_m();
      r = int'($urandom_range(0, 99));
      rst    = (r < 2);
      StallW = (r >= 2 && r < 22);
      FlushW = (r >= 22 && r < 30);
      tick();
      checks++;
      if (ResultW !== exp_result() || RegWriteW !== exp_we() || RdW !== mrd ||
          ValidW !== mv || InstRetW !== mcnt || inst4 !== mcnt[3:0]) begin
        failures++;
        $display("FAIL random cyc%0d: got res=%h we=%b rd=%0d v=%b ir=%0d ir4=%0d, want res=%h we=%b rd=%0d v=%b ir=%0d",
                 i, ResultW, RegWriteW, RdW, ValidW, InstRetW, inst4,
                 exp_result(), exp_we(), mrd, mv, mcnt);
      end
    end
    rst = 0; StallW = 0; FlushW = 0;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      randomize_m(); ValidM = 1;
      tick();
    end
    ValidM = 0;
    tick();
    checks++;
    if (inst4 !== 4'd1 || InstRetW !== 64'd17 || InstRetW !== mcnt) begin
      failures++;
      $display("FAIL wrap: got ir4=%0d ir=%0d, want ir4=1 ir=17", inst4, InstRetW);
    end
    ValidM = 1;
    tick();
    rst = 1;
    tick();
    rst = 0; ValidM = 0;
    tick();
    checks++;
    if (InstRetW !== 64'd0 || inst4 !== 4'd0 || ValidW !== 1'b0) begin
      failures++;
      $display("FAIL reset_drop: got ir=%0d ir4=%0d v=%b, want 0 0 0", InstRetW, inst4, ValidW);
    end
  endtask

  initial begin
    rst = 1; StallW = 0; FlushW = 0;
    set_m(0, 0, 2'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    model_clear();
    mcnt = 0;
    test_reset();
    test_result_mux();
    test_load_extend();
    test_x0();
    test_stall_flush();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
